delay_chain_ctrl: RTL and testbench

Stream-side controller that sits directly upstream of the reconfigurable delay chain and also consumes its output. It converts a valid/ready input stream into the chain's enable/data strobes and applies run-time length changes only at safe points. It suppresses the unreliable outputs that follow reset or a length change, then presents clean delayed samples on a valid/ready output stream with backpressure.

---
 rtl/delay_chain_ctrl_pkg.sv | 24 ++
 rtl/delay_chain_ctrl_if.sv | 39 +++
 rtl/delay_chain_ctrl_fill.sv | 40 ++++
 rtl/delay_chain_ctrl.sv | 142 ++++++++++++++
 tb/tb_delay_chain_ctrl.sv | 328 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/delay_chain_ctrl_pkg.sv
// Shared types and helpers for the delay chain controller: state encoding, length type
// and the length clamp applied to run-time length requests.
package delay_chain_pkg;

   localparam int PKG_MAX_LEN = 32;
   localparam int PKG_LW      = $clog2(PKG_MAX_LEN + 1);

   typedef logic [PKG_LW-1:0] len_t;

   typedef enum logic {
      ST_FILL = 1'b0,
      ST_RUN  = 1'b1
   } ctrl_state_e;

   // Works on plain integers so instances with a different MAX_LEN can share it.
   function automatic int unsigned clamp_len(input int unsigned len,
                                             input int unsigned min_len,
                                             input int unsigned max_len);
      if (len < min_len) return min_len;
      if (len > max_len) return max_len;
      return len;
   endfunction

endpackage

// File: rtl/delay_chain_ctrl_if.sv
// Bundle of the controller's stream, config and chain-side signals.
// slave = controller view, master = surrounding logic / chain view.
interface delay_chain_ctrl_if #(
   parameter int DW = 8,
   parameter int LW = 6
);
   logic          s_valid;
   logic          s_ready;
   logic [DW-1:0] s_data;

   logic          cfg_valid;
   logic          cfg_ready;
   logic [LW-1:0] cfg_len;
   logic          cfg_clamped;
   logic [LW-1:0] cur_len;
   logic          primed;

   logic          chain_en;
   logic [LW-1:0] chain_length;
   logic [DW-1:0] chain_din;
   logic [DW-1:0] chain_dout;

   logic          m_valid;
   logic          m_ready;
   logic [DW-1:0] m_data;

   modport slave (
      input  s_valid, s_data, cfg_valid, cfg_len, chain_dout, m_ready,
      output s_ready, cfg_ready, cfg_clamped, cur_len, primed,
             chain_en, chain_length, chain_din, m_valid, m_data
   );

   modport master (
      output s_valid, s_data, cfg_valid, cfg_len, chain_dout, m_ready,
      input  s_ready, cfg_ready, cfg_clamped, cur_len, primed,
             chain_en, chain_length, chain_din, m_valid, m_data
   );

endinterface

// File: rtl/delay_chain_ctrl_fill.sv
// Fill counter: counts samples pushed into the chain since the last restart and
// strobes done on the increment that reaches the target length.
module dly_fill_counter #(
   parameter int LW = 6
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          clear,
   input  logic          incr,
   input  logic [LW-1:0] target,
   output logic          done
);

   logic [LW-1:0] fill_cnt_q;
   logic [LW-1:0] fill_cnt_d;
   logic [LW-1:0] fill_cnt_inc;

   assign fill_cnt_inc = fill_cnt_q + LW'(1);

   always_comb begin
      fill_cnt_d = fill_cnt_q;
      if (clear) begin
         fill_cnt_d = '0;
      end else if (incr) begin
         fill_cnt_d = fill_cnt_inc;
      end
   end

   // The owner stops incrementing once done fires, so the count never passes target.
   assign done = incr & ~clear & (fill_cnt_inc == target);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         fill_cnt_q <= '0;
      end else begin
         fill_cnt_q <= fill_cnt_d;
      end
   end

endmodule

// File: rtl/delay_chain_ctrl.sv
// Stream controller in front of a reconfigurable delay chain: discards the fill after reset or a
// length change, then forwards delayed samples. Define DELAY_CHAIN_CTRL_STATS_EN for discard_cnt.
module delay_chain_ctrl
   import delay_chain_pkg::*;
#(
   parameter int  DW      = 8,
   parameter int  MAX_LEN = 32,
   parameter int  MIN_LEN = 2,
   parameter int  DEF_LEN = 8,
   localparam int LW      = $clog2(MAX_LEN + 1)
) (
   input  logic               clk,
   input  logic               rst_n,
   delay_chain_ctrl_if.slave  bus
`ifdef DELAY_CHAIN_CTRL_STATS_EN
   ,
   output logic [15:0]        discard_cnt
`endif
);

   ctrl_state_e   state_q;
   ctrl_state_e   state_d;
   logic [LW-1:0] cur_len_q;
   logic [LW-1:0] cur_len_d;
   logic          m_valid_q;
   logic          m_valid_d;
   logic          cfg_clamped_q;
   logic          cfg_clamped_d;

   logic [LW-1:0] clamped_len;
   logic          cfg_ready;
   logic          cfg_acc;
   logic          s_ready;
   logic          acc;
   logic          fill_incr;
   logic          fill_done;
   logic          primed;

   assign clamped_len = LW'(clamp_len(32'(bus.cfg_len), MIN_LEN, MAX_LEN));

   // Handshake: a length change only when no output is pending, and it beats data.
   always_comb begin
      cfg_ready = ~m_valid_q;
      cfg_acc   = bus.cfg_valid & cfg_ready;
      s_ready   = (~m_valid_q | bus.m_ready) & ~cfg_acc;
      acc       = bus.s_valid & s_ready;
      fill_incr = acc & (state_q == ST_FILL);
      primed    = (state_q == ST_RUN);
   end

   dly_fill_counter #(
      .LW (LW)
   ) u_fill (
      .clk    (clk),
      .rst_n  (rst_n),
      .clear  (cfg_acc),
      .incr   (fill_incr),
      .target (cur_len_q),
      .done   (fill_done)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_FILL;
      end else begin
         state_q <= state_d;
      end
   end

   // Any accepted request restarts the fill, even with an unchanged length.
   always_comb begin
      state_d = state_q;
      if (cfg_acc) begin
         state_d = ST_FILL;
      end else if ((state_q == ST_FILL) && fill_done) begin
         state_d = ST_RUN;
      end
   end

   always_comb begin
      cur_len_d     = cur_len_q;
      cfg_clamped_d = 1'b0;
      if (cfg_acc) begin
         cur_len_d     = clamped_len;
         cfg_clamped_d = (clamped_len != bus.cfg_len);
      end
      if (acc && (state_q == ST_RUN)) begin
         m_valid_d = 1'b1;
      end else if (bus.m_ready) begin
         m_valid_d = 1'b0;
      end else begin
         m_valid_d = m_valid_q;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cur_len_q     <= LW'(DEF_LEN);
         m_valid_q     <= 1'b0;
         cfg_clamped_q <= 1'b0;
      end else begin
         cur_len_q     <= cur_len_d;
         m_valid_q     <= m_valid_d;
         cfg_clamped_q <= cfg_clamped_d;
      end
   end

   // Chain enable tracks acceptance, so the chain holds its output under backpressure.
   assign bus.s_ready      = s_ready;
   assign bus.cfg_ready    = cfg_ready;
   assign bus.cfg_clamped  = cfg_clamped_q;
   assign bus.cur_len      = cur_len_q;
   assign bus.primed       = primed;
   assign bus.chain_en     = acc;
   assign bus.chain_length = cur_len_q;
   assign bus.chain_din    = bus.s_data[DW-1:0];
   assign bus.m_valid      = m_valid_q;
   assign bus.m_data       = bus.chain_dout[DW-1:0];

`ifdef DELAY_CHAIN_CTRL_STATS_EN
   logic [15:0] discard_cnt_q;
   logic [15:0] discard_cnt_d;

   always_comb begin
      discard_cnt_d = discard_cnt_q;
      if (fill_incr && (discard_cnt_q != 16'hFFFF)) begin
         discard_cnt_d = discard_cnt_q + 16'd1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         discard_cnt_q <= '0;
      end else begin
         discard_cnt_q <= discard_cnt_d;
      end
   end

   assign discard_cnt = discard_cnt_q;
`endif

endmodule

// File: tb/tb_delay_chain_ctrl.sv
// Bench for delay_chain_ctrl: directed scenarios plus a randomized run against a
// queue-based reference model; a simple shift-register stands in for the delay chain.
module tb_delay_chain_ctrl;

   localparam int DW      = 8;
   localparam int MAX_LEN = 32;
   localparam int MIN_LEN = 2;
   localparam int DEF_LEN = 8;
   localparam int LW      = 6;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   delay_chain_ctrl_if #(.DW(DW), .LW(LW)) bus ();

`ifdef DELAY_CHAIN_CTRL_STATS_EN
   logic [15:0] discard_cnt;
`endif

   delay_chain_ctrl #(
      .DW      (DW),
      .MAX_LEN (MAX_LEN),
      .MIN_LEN (MIN_LEN),
      .DEF_LEN (DEF_LEN)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
`ifdef DELAY_CHAIN_CTRL_STATS_EN
      ,
      .discard_cnt (discard_cnt)
`endif
   );

   // Chain stand-in: dout after an enabled edge is the sample chain_length accepts back.
   logic [DW-1:0] sr [0:MAX_LEN-1];
   logic [DW-1:0] chain_dout_r = '0;
   always @(posedge clk) begin
      if (bus.chain_en) begin
         for (int i = MAX_LEN - 1; i > 0; i--) sr[i] <= sr[i-1];
         sr[0]        <= bus.chain_din;
         chain_dout_r <= sr[bus.chain_length - 6'd1];
      end
   end
   assign bus.chain_dout = chain_dout_r;

   int n_vec = 0;
   int n_err = 0;

   // Reference model: samples accepted since the last fill start, plus output register.
   int          mdl_len;
   bit          mdl_mvalid;
   logic [7:0]  mdl_mdata;
   bit          mdl_clamped;
   int          mdl_disc;
   logic [7:0]  mdl_hist[$];

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      bus.s_valid   = 1'b0;
      bus.s_data    = '0;
      bus.cfg_valid = 1'b0;
      bus.cfg_len   = '0;
      bus.m_ready   = 1'b1;
   endtask

   task automatic apply_reset();
      idle_inputs();
      rst_n = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
   endtask

   task automatic mdl_reset();
      mdl_len     = DEF_LEN;
      mdl_mvalid  = 1'b0;
      mdl_mdata   = '0;
      mdl_clamped = 1'b0;
      mdl_disc    = 0;
      mdl_hist.delete();
   endtask

   // Advance the model by one clock using the inputs currently driven.
   task automatic mdl_tick();
      bit cfg_acc, acc;
      int req, nl;
      cfg_acc     = bus.cfg_valid && !mdl_mvalid;
      acc         = bus.s_valid && (!mdl_mvalid || bus.m_ready) && !cfg_acc;
      mdl_clamped = 1'b0;
      if (cfg_acc) begin
         req = int'(bus.cfg_len);
         nl  = (req < MIN_LEN) ? MIN_LEN : ((req > MAX_LEN) ? MAX_LEN : req);
         mdl_clamped = (nl != req);
         mdl_len     = nl;
         mdl_hist.delete();
      end else if (acc) begin
         mdl_hist.push_back(bus.s_data);
         if (mdl_hist.size() > mdl_len) begin
            mdl_mvalid = 1'b1;
            mdl_mdata  = mdl_hist[mdl_hist.size() - 1 - mdl_len];
            return;
         end
         mdl_disc++;
      end
      if (bus.m_ready) mdl_mvalid = 1'b0;
   endtask

   task automatic test_reset();
      apply_reset();
      #2;
      n_vec++; if (bus.m_valid !== 1'b0) begin n_err++; $display("FAIL reset_m_valid got=%b exp=0", bus.m_valid); end
      n_vec++; if (bus.cur_len !== 6'(DEF_LEN)) begin n_err++; $display("FAIL reset_cur_len got=%0d exp=%0d", bus.cur_len, DEF_LEN); end
      n_vec++; if (bus.chain_length !== 6'(DEF_LEN)) begin n_err++; $display("FAIL reset_chain_length got=%0d exp=%0d", bus.chain_length, DEF_LEN); end
      n_vec++; if (bus.primed !== 1'b0) begin n_err++; $display("FAIL reset_primed got=%b exp=0", bus.primed); end
      n_vec++; if (bus.cfg_clamped !== 1'b0) begin n_err++; $display("FAIL reset_cfg_clamped got=%b exp=0", bus.cfg_clamped); end
      n_vec++; if (bus.cfg_ready !== 1'b1) begin n_err++; $display("FAIL reset_cfg_ready got=%b exp=1", bus.cfg_ready); end
      n_vec++; if (bus.s_ready !== 1'b1) begin n_err++; $display("FAIL reset_s_ready got=%b exp=1", bus.s_ready); end
`ifdef DELAY_CHAIN_CTRL_STATS_EN
      n_vec++; if (discard_cnt !== 16'd0) begin n_err++; $display("FAIL reset_discard_cnt got=%0d exp=0", discard_cnt); end
`endif
      tick();
   endtask

   task automatic test_fill();
      for (int i = 1; i <= 12; i++) begin
         bus.s_valid = 1'b1;
         bus.s_data  = 8'(i);
         #2;
         n_vec++; if (bus.chain_en !== 1'b1) begin n_err++; $display("FAIL fill_chain_en i=%0d got=%b exp=1", i, bus.chain_en); end
         n_vec++; if (bus.chain_din !== 8'(i)) begin n_err++; $display("FAIL fill_chain_din i=%0d got=%0h exp=%0h", i, bus.chain_din, i); end
         n_vec++; if (bus.primed !== (i >= 9)) begin n_err++; $display("FAIL fill_primed i=%0d got=%b exp=%b", i, bus.primed, i >= 9); end
         n_vec++; if (bus.m_valid !== (i >= 10)) begin n_err++; $display("FAIL fill_m_valid i=%0d got=%b exp=%b", i, bus.m_valid, i >= 10); end
         if (i >= 10) begin
            n_vec++; if (bus.m_data !== 8'(i - 9)) begin n_err++; $display("FAIL fill_m_data i=%0d got=%0h exp=%0h", i, bus.m_data, i - 9); end
         end
         tick();
      end
      bus.s_valid = 1'b0;
      #2;
      n_vec++; if (bus.m_valid !== 1'b1) begin n_err++; $display("FAIL fill_last_valid got=%b exp=1", bus.m_valid); end
      n_vec++; if (bus.m_data !== 8'd4) begin n_err++; $display("FAIL fill_last_data got=%0h exp=4", bus.m_data); end
`ifdef DELAY_CHAIN_CTRL_STATS_EN
      n_vec++; if (discard_cnt !== 16'd8) begin n_err++; $display("FAIL fill_discard_cnt got=%0d exp=8", discard_cnt); end
`endif
      tick();
   endtask

   task automatic test_cfg_len4();
      bus.cfg_valid = 1'b1;
      bus.cfg_len   = 6'd4;
      #2;
      n_vec++; if (bus.cfg_ready !== 1'b1) begin n_err++; $display("FAIL len4_cfg_ready got=%b exp=1", bus.cfg_ready); end
      tick();
      bus.cfg_valid = 1'b0;
      #2;
      n_vec++; if (bus.cur_len !== 6'd4) begin n_err++; $display("FAIL len4_cur_len got=%0d exp=4", bus.cur_len); end
      n_vec++; if (bus.chain_length !== 6'd4) begin n_err++; $display("FAIL len4_chain_length got=%0d exp=4", bus.chain_length); end
      n_vec++; if (bus.primed !== 1'b0) begin n_err++; $display("FAIL len4_primed got=%b exp=0", bus.primed); end
      n_vec++; if (bus.cfg_clamped !== 1'b0) begin n_err++; $display("FAIL len4_clamped got=%b exp=0", bus.cfg_clamped); end
      for (int i = 1; i <= 8; i++) begin
         bus.s_valid = 1'b1;
         bus.s_data  = 8'(8'h0F + i);
         #2;
         n_vec++; if (bus.m_valid !== (i >= 6)) begin n_err++; $display("FAIL len4_m_valid i=%0d got=%b exp=%b", i, bus.m_valid, i >= 6); end
         if (i >= 6) begin
            n_vec++; if (bus.m_data !== 8'(8'h0A + i)) begin n_err++; $display("FAIL len4_m_data i=%0d got=%0h exp=%0h", i, bus.m_data, 8'h0A + i); end
         end
         tick();
      end
      bus.s_valid = 1'b0;
      #2;
      n_vec++; if (bus.m_data !== 8'h13 || bus.m_valid !== 1'b1) begin n_err++; $display("FAIL len4_last got=%b/%0h exp=1/13", bus.m_valid, bus.m_data); end
      tick();
   endtask

   task automatic test_backpressure();
      bus.s_valid = 1'b1;
      bus.s_data  = 8'h20;
      tick();
      bus.s_data  = 8'h21;
      bus.m_ready = 1'b0;
      repeat (5) begin
         #2;
         n_vec++; if (bus.s_ready !== 1'b0) begin n_err++; $display("FAIL bp_s_ready got=%b exp=0", bus.s_ready); end
         n_vec++; if (bus.chain_en !== 1'b0) begin n_err++; $display("FAIL bp_chain_en got=%b exp=0", bus.chain_en); end
         n_vec++; if (bus.m_valid !== 1'b1) begin n_err++; $display("FAIL bp_m_valid got=%b exp=1", bus.m_valid); end
         n_vec++; if (bus.m_data !== 8'h14) begin n_err++; $display("FAIL bp_m_data got=%0h exp=14", bus.m_data); end
         tick();
      end
      for (int j = 0; j < 3; j++) begin
         bus.m_ready = 1'b1;
         bus.s_data  = 8'(8'h21 + j);
         #2;
         n_vec++; if (bus.s_ready !== 1'b1) begin n_err++; $display("FAIL bp_rel_s_ready j=%0d got=%b exp=1", j, bus.s_ready); end
         n_vec++; if (bus.m_valid !== 1'b1) begin n_err++; $display("FAIL bp_rel_m_valid j=%0d got=%b exp=1", j, bus.m_valid); end
         n_vec++; if (bus.m_data !== 8'(8'h14 + j)) begin n_err++; $display("FAIL bp_rel_m_data j=%0d got=%0h exp=%0h", j, bus.m_data, 8'h14 + j); end
         tick();
      end
      bus.s_valid = 1'b0;
      #2;
      n_vec++; if (bus.m_data !== 8'h17 || bus.m_valid !== 1'b1) begin n_err++; $display("FAIL bp_last got=%b/%0h exp=1/17", bus.m_valid, bus.m_data); end
      tick();
      #2;
      n_vec++; if (bus.m_valid !== 1'b0) begin n_err++; $display("FAIL bp_drain got=%b exp=0", bus.m_valid); end
      tick();
   endtask

   task automatic test_clamp();
      int req_tab[5]  = '{0, 40, 5, 32, 1};
      int len_tab[5]  = '{2, 32, 5, 32, 2};
      bit clmp_tab[5] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
      for (int t = 0; t < 5; t++) begin
         bus.cfg_valid = 1'b1;
         bus.cfg_len   = 6'(req_tab[t]);
         #2;
         n_vec++; if (bus.cfg_ready !== 1'b1) begin n_err++; $display("FAIL clamp_cfg_ready req=%0d got=%b exp=1", req_tab[t], bus.cfg_ready); end
         tick();
         bus.cfg_valid = 1'b0;
         #2;
         n_vec++; if (bus.cur_len !== 6'(len_tab[t])) begin n_err++; $display("FAIL clamp_cur_len req=%0d got=%0d exp=%0d", req_tab[t], bus.cur_len, len_tab[t]); end
         n_vec++; if (bus.cfg_clamped !== clmp_tab[t]) begin n_err++; $display("FAIL clamp_pulse req=%0d got=%b exp=%b", req_tab[t], bus.cfg_clamped, clmp_tab[t]); end
         tick();
         #2;
         n_vec++; if (bus.cfg_clamped !== 1'b0) begin n_err++; $display("FAIL clamp_pulse_end req=%0d got=%b exp=0", req_tab[t], bus.cfg_clamped); end
         tick();
      end
   endtask

   task automatic test_cfg_priority();
      bus.cfg_valid = 1'b1;
      bus.cfg_len   = 6'd3;
      bus.s_valid   = 1'b1;
      bus.s_data    = 8'hAA;
      bus.m_ready   = 1'b1;
      #2;
      n_vec++; if (bus.cfg_ready !== 1'b1) begin n_err++; $display("FAIL prio_cfg_ready got=%b exp=1", bus.cfg_ready); end
      n_vec++; if (bus.s_ready !== 1'b0) begin n_err++; $display("FAIL prio_s_ready got=%b exp=0", bus.s_ready); end
      n_vec++; if (bus.chain_en !== 1'b0) begin n_err++; $display("FAIL prio_chain_en got=%b exp=0", bus.chain_en); end
      tick();
      bus.cfg_valid = 1'b0;
      for (int i = 0; i < 4; i++) begin
         bus.s_data = 8'(8'hAB + i);
         #2;
         n_vec++; if (bus.chain_en !== 1'b1) begin n_err++; $display("FAIL prio_accept i=%0d got=%b exp=1", i, bus.chain_en); end
         n_vec++; if (bus.m_valid !== 1'b0) begin n_err++; $display("FAIL prio_m_valid i=%0d got=%b exp=0", i, bus.m_valid); end
         if (i == 0) begin
            n_vec++; if (bus.cur_len !== 6'd3) begin n_err++; $display("FAIL prio_cur_len got=%0d exp=3", bus.cur_len); end
         end
         tick();
      end
      bus.s_valid = 1'b0;
      bus.m_ready = 1'b0;
      #2;
      n_vec++; if (bus.m_valid !== 1'b1 || bus.m_data !== 8'hAB) begin n_err++; $display("FAIL prio_out got=%b/%0h exp=1/ab", bus.m_valid, bus.m_data); end
      n_vec++; if (bus.primed !== 1'b1) begin n_err++; $display("FAIL prio_primed got=%b exp=1", bus.primed); end
      tick();
   endtask

   task automatic test_async_reset();
      #2;
      n_vec++; if (bus.m_valid !== 1'b1) begin n_err++; $display("FAIL arst_pre_m_valid got=%b exp=1", bus.m_valid); end
      rst_n = 1'b0;
      #1;
      n_vec++; if (bus.m_valid !== 1'b0) begin n_err++; $display("FAIL arst_m_valid got=%b exp=0", bus.m_valid); end
      n_vec++; if (bus.cur_len !== 6'(DEF_LEN)) begin n_err++; $display("FAIL arst_cur_len got=%0d exp=%0d", bus.cur_len, DEF_LEN); end
      n_vec++; if (bus.primed !== 1'b0) begin n_err++; $display("FAIL arst_primed got=%b exp=0", bus.primed); end
`ifdef DELAY_CHAIN_CTRL_STATS_EN
      n_vec++; if (discard_cnt !== 16'd0) begin n_err++; $display("FAIL arst_discard_cnt got=%0d exp=0", discard_cnt); end
`endif
      idle_inputs();
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
   endtask

   task automatic test_random();
      bit e_cfg_acc, e_s_ready, e_acc;
      apply_reset();
      mdl_reset();
      for (int c = 0; c < 3000; c++) begin
         bus.s_valid   = ($urandom_range(0, 9) < 7);
         bus.s_data    = 8'($urandom);
         bus.cfg_valid = ($urandom_range(0, 49) == 0);
         bus.cfg_len   = 6'($urandom_range(0, 40));
         bus.m_ready   = ($urandom_range(0, 9) < 7);
         #2;
         e_cfg_acc = bus.cfg_valid && !mdl_mvalid;
         e_s_ready = (!mdl_mvalid || bus.m_ready) && !e_cfg_acc;
         e_acc     = bus.s_valid && e_s_ready;
         n_vec++; if (bus.cfg_ready !== !mdl_mvalid) begin n_err++; $display("FAIL rnd_cfg_ready c=%0d got=%b exp=%b", c, bus.cfg_ready, !mdl_mvalid); end
         n_vec++; if (bus.s_ready !== e_s_ready) begin n_err++; $display("FAIL rnd_s_ready c=%0d got=%b exp=%b", c, bus.s_ready, e_s_ready); end
         n_vec++; if (bus.chain_en !== e_acc) begin n_err++; $display("FAIL rnd_chain_en c=%0d got=%b exp=%b", c, bus.chain_en, e_acc); end
         n_vec++; if (bus.m_valid !== mdl_mvalid) begin n_err++; $display("FAIL rnd_m_valid c=%0d got=%b exp=%b", c, bus.m_valid, mdl_mvalid); end
         n_vec++; if (bus.cur_len !== 6'(mdl_len)) begin n_err++; $display("FAIL rnd_cur_len c=%0d got=%0d exp=%0d", c, bus.cur_len, mdl_len); end
         n_vec++; if (bus.primed !== (mdl_hist.size() >= mdl_len)) begin n_err++; $display("FAIL rnd_primed c=%0d got=%b exp=%b", c, bus.primed, mdl_hist.size() >= mdl_len); end
         n_vec++; if (bus.cfg_clamped !== mdl_clamped) begin n_err++; $display("FAIL rnd_clamped c=%0d got=%b exp=%b", c, bus.cfg_clamped, mdl_clamped); end
         if (mdl_mvalid) begin
            n_vec++; if (bus.m_data !== mdl_mdata) begin n_err++; $display("FAIL rnd_m_data c=%0d got=%0h exp=%0h", c, bus.m_data, mdl_mdata); end
         end
         mdl_tick();
         tick();
      end
`ifdef DELAY_CHAIN_CTRL_STATS_EN
      n_vec++; if (discard_cnt !== 16'(mdl_disc)) begin n_err++; $display("FAIL rnd_discard_cnt got=%0d exp=%0d", discard_cnt, mdl_disc); end
`endif
   endtask

   initial begin
      idle_inputs();
      test_reset();
      test_fill();
      test_cfg_len4();
      test_backpressure();
      test_clamp();
      test_cfg_priority();
      test_async_reset();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
